ram_multiport: RTL and testbench
================================

Name: ram_multiport

Overview:
- Parametrised successor to the processor's single-read-port data/instruction RAM.
- Provides N independent registered read ports, one byte-enabled write port and a selectable read-during-write policy.
- Adds a hardware clear sequencer that zeroes the array after reset or on request, so the array itself carries no reset logic.
- Sits between the processor's load/store and fetch paths and the memory array.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDRESS_WIDTH, 12, address bits; depth = 2**ADDRESS_WIDTH words.
- BYTE_WIDTH, 8, bits per write-enable lane.
- NUM_READ_PORTS, 2, number of read ports; must be >= 1.
- RDW_MODE, 0, read-during-write at the same address: 0 = return old data, 1 = return new (write-through) data.
- CLEAR_ON_RESET, 1, 1 = start a clear sweep automatically when reset deasserts.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- reset  input  1  asynchronous, active-low reset.
- clear_req  input  1  one-cycle pulse requesting a full zero sweep; honoured only when busy=0.
- busy  output  1  high while the clear sweep runs.
- w_en  input  1  write enable.
- w_adrs  input  ADDRESS_WIDTH  write address.
- w_be  input  DATA_WIDTH/BYTE_WIDTH  byte-lane write enables.
- w_data  input  DATA_WIDTH  write data.
- r_en  input  NUM_READ_PORTS  per-port read enable.
- r_adrs  input  NUM_READ_PORTS*ADDRESS_WIDTH  packed read addresses; port p uses slice p.
- r_data  output  NUM_READ_PORTS*DATA_WIDTH  packed registered read data.
- r_valid  output  NUM_READ_PORTS  high for one cycle when r_data[p] was updated on the preceding edge.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - state = CLEAR if CLEAR_ON_RESET=1, else READY.
  - clear counter = 0; busy follows state.
  - r_data = 0; r_valid = 0.
  - Array contents are not reset.
- State machine states: CLEAR, READY.
- CLEAR state:
  - Each falling edge writes 0 to memory[counter] and increments counter.
  - At counter = 2**ADDRESS_WIDTH-1, that word is written and state moves to READY on the same edge.
  - A sweep therefore takes exactly 2**ADDRESS_WIDTH edges.
  - busy=1; w_en, r_en and clear_req are ignored; r_valid stays 0; r_data holds.
- READY state:
  - busy=0.
  - clear_req=1 sets counter=0 and state=CLEAR on the next edge. Any write or read in that same cycle is still performed.
- Write:
  - On an edge with w_en=1, each lane i with w_be[i]=1 updates memory[w_adrs] bits [i*BYTE_WIDTH +: BYTE_WIDTH].
  - Lanes with w_be[i]=0 are unchanged; w_be all-zero is a no-op.
- Read, latency 1 edge, per port:
  - r_en[p]=1: r_data[p] is loaded from memory[r_adrs[p]] and r_valid[p]=1 on the next edge.
  - r_en[p]=0: r_data[p] holds and r_valid[p]=0.
- Read-during-write, same edge, r_adrs[p]=w_adrs, w_en=1:
  - RDW_MODE=0: r_data[p] gets the pre-write word.
  - RDW_MODE=1: r_data[p] gets the merged word (new bytes where w_be=1, old bytes elsewhere).
- Multiple ports may read the same address on the same edge; each returns the identical word.
- Reset mid-sweep: the sweep restarts from address 0 (CLEAR_ON_RESET=1) or is abandoned (CLEAR_ON_RESET=0).
- Elaboration checks: DATA_WIDTH % BYTE_WIDTH != 0 or NUM_READ_PORTS < 1 is a fatal error.

Decomposition:
- Package ram_pkg holds:
  - typedef enum ram_state_t {RAM_CLEAR, RAM_READY}.
  - localparams RDW_OLD=0 and RDW_NEW=1.
  - A function for the byte-lane merge (old word, new word, be).
- Sub-module ram_read_port, instantiated NUM_READ_PORTS times via generate:
  - Inputs: the array word, the write bus and the RDW bypass.
  - Owns the r_data/r_valid registers.
- The top level owns the array, the write logic and the clear FSM/counter.

Test Plan (bench uses ADDRESS_WIDTH=4, DATA_WIDTH=32, NUM_READ_PORTS=2):
- Release reset with CLEAR_ON_RESET=1 -> busy=1 for exactly 16 falling edges, then 0; reading every address returns 0x0000_0000 with r_valid=1 one edge after r_en.
- Write 0xDEAD_BEEF to addr 3 with w_be=4'b1111, then 0x0000_00AA with w_be=4'b0001 -> read of addr 3 returns 0xDEAD_BEAA.
- RDW_MODE=0: addr 5 holds 0x1111_1111; same edge write 0x2222_2222 and port-0 read addr 5 -> r_data0=0x1111_1111, next read returns 0x2222_2222. RDW_MODE=1: same stimulus -> r_data0=0x2222_2222.
- Port 0 reads addr 7 and port 1 reads addr 7 on the same edge -> both return the same word; with r_en=2'b01, r_valid=2'b01 and r_data1 holds its prior value.
- Pulse clear_req with memory non-zero -> busy=1 for 16 edges, w_en during busy leaves the array unchanged, all words read 0 afterwards.
- Assert reset at sweep edge 8 -> r_valid=0 and r_data=0 immediately; after release a fresh 16-edge sweep runs from address 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-port RAM and its read ports.
package ram_pkg;

   typedef enum logic {RAM_CLEAR, RAM_READY} ram_state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Widest word the merge helper handles; callers size-cast in and out.
   localparam int RAM_MAX_DW = 512;

   // Byte-lane merge: lanes with be set take the new word, the rest keep the old word.
   function automatic logic [RAM_MAX_DW-1:0] byte_merge(
      input logic [RAM_MAX_DW-1:0] old_word,
      input logic [RAM_MAX_DW-1:0] new_word,
      input logic [RAM_MAX_DW-1:0] be,
      input int                    byte_width
   );
      logic [RAM_MAX_DW-1:0] res;
      res = old_word;
      for (int b = 0; b < RAM_MAX_DW; b++) begin
         if (be[b / byte_width]) res[b] = new_word[b];
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_read_port.sv
// One registered read port with optional write-through bypass.
module ram_read_port
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12,
   parameter int RDW_MODE      = RDW_OLD
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_en,
   input  logic [ADDRESS_WIDTH-1:0] i_adrs,
   input  logic [DATA_WIDTH-1:0]    i_word,
   input  logic                     i_w_en,
   input  logic [ADDRESS_WIDTH-1:0] i_w_adrs,
   input  logic [DATA_WIDTH-1:0]    i_w_merged,
   output logic [DATA_WIDTH-1:0]    o_data,
   output logic                     o_valid
);

   logic                  w_hit;
   logic [DATA_WIDTH-1:0] w_next;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;

   // A same-address write on this edge only matters in write-through mode.
   assign w_hit  = (RDW_MODE == RDW_NEW) && i_w_en && (i_w_adrs == i_adrs);
   assign w_next = w_hit ? i_w_merged : i_word;

   // Capture the addressed word on each enabled edge; hold data otherwise.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_en;
         if (i_en) r_data <= w_next;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/ram_multiport.sv
// Multi-read-port RAM with byte-enabled write port and a hardware clear sweep.
module ram_multiport
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 12,
   parameter int BYTE_WIDTH     = 8,
   parameter int NUM_READ_PORTS = 2,
   parameter int RDW_MODE       = RDW_OLD,
   parameter int CLEAR_ON_RESET = 1
)(
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   clear_req,
   output logic                                   busy,
   input  logic                                   w_en,
   input  logic [ADDRESS_WIDTH-1:0]               w_adrs,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]       w_be,
   input  logic [DATA_WIDTH-1:0]                  w_data,
   input  logic [NUM_READ_PORTS-1:0]              r_en,
   input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0] r_adrs,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]   r_data,
   output logic [NUM_READ_PORTS-1:0]              r_valid
);

   localparam int DEPTH = 2**ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADRS = {ADDRESS_WIDTH{1'b1}};
   localparam ram_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_READY;

   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
      $fatal(1, "ram_multiport: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (NUM_READ_PORTS < 1) begin : g_bad_ports
      $fatal(1, "ram_multiport: NUM_READ_PORTS must be >= 1");
   end
   if (DATA_WIDTH > RAM_MAX_DW) begin : g_bad_width
      $fatal(1, "ram_multiport: DATA_WIDTH exceeds merge helper width");
   end

   logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
   ram_state_t                r_state;
   ram_state_t                w_state_next;
   logic [ADDRESS_WIDTH-1:0]  r_count;
   logic [ADDRESS_WIDTH-1:0]  w_count_next;
   logic                      w_ready;
   logic                      w_wr_en;
   logic [NUM_READ_PORTS-1:0] w_rd_en;
   logic [DATA_WIDTH-1:0]     w_old;
   logic [DATA_WIDTH-1:0]     w_merged;

   // User traffic is only accepted outside the sweep.
   assign w_ready  = (r_state == RAM_READY);
   assign busy     = ~w_ready;
   assign w_wr_en  = w_ready & w_en;
   assign w_rd_en  = w_ready ? r_en : '0;
   assign w_old    = r_mem[w_adrs];
   assign w_merged = DATA_WIDTH'(byte_merge(RAM_MAX_DW'(w_old), RAM_MAX_DW'(w_data),
                                            RAM_MAX_DW'(w_be), BYTE_WIDTH));

   // Clear sequencer state and sweep counter.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RESET_STATE;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
      end
   end

   // Sweep advances one word per edge; a clear request restarts it from zero.
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      case (r_state)
         RAM_CLEAR: begin
            w_count_next = r_count + ADDRESS_WIDTH'(1);
            if (r_count == LAST_ADRS) w_state_next = RAM_READY;
         end
         RAM_READY: begin
            if (clear_req) begin
               w_state_next = RAM_CLEAR;
               w_count_next = '0;
            end
         end
         default: w_state_next = RESET_STATE;
      endcase
   end

   // Array has no reset; it is zeroed by the sweep and held still while reset is low.
   always_ff @(negedge clk) begin
      if (reset) begin
         if (!w_ready)     r_mem[r_count] <= '0;
         else if (w_wr_en) r_mem[w_adrs]  <= w_merged;
      end
   end

   for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
      ram_read_port #(
         .DATA_WIDTH    (DATA_WIDTH),
         .ADDRESS_WIDTH (ADDRESS_WIDTH),
         .RDW_MODE      (RDW_MODE)
      ) u_port (
         .clk        (clk),
         .reset      (reset),
         .i_en       (w_rd_en[p]),
         .i_adrs     (r_adrs[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
         .i_word     (r_mem[r_adrs[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]]),
         .i_w_en     (w_wr_en),
         .i_w_adrs   (w_adrs),
         .i_w_merged (w_merged),
         .o_data     (r_data[p*DATA_WIDTH +: DATA_WIDTH]),
         .o_valid    (r_valid[p])
      );
   end

endmodule

// File: tb/tb_ram_multiport.sv
// Scoreboard bench: one instance per read-during-write mode, driven in lockstep.
module tb_ram_multiport;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clear_req = 1'b0;
   logic        w_en = 1'b0;
   logic [3:0]  w_adrs = '0;
   logic [3:0]  w_be = '0;
   logic [31:0] w_data = '0;
   logic [1:0]  r_en = '0;
   logic [7:0]  r_adrs = '0;

   logic        busy0, busy1;
   logic [63:0] r_data0, r_data1;
   logic [1:0]  r_valid0, r_valid1;

   ram_multiport #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8),
                   .NUM_READ_PORTS(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_old (
      .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy0),
      .w_en(w_en), .w_adrs(w_adrs), .w_be(w_be), .w_data(w_data),
      .r_en(r_en), .r_adrs(r_adrs), .r_data(r_data0), .r_valid(r_valid0));

   ram_multiport #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8),
                   .NUM_READ_PORTS(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut_new (
      .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy1),
      .w_en(w_en), .w_adrs(w_adrs), .w_be(w_be), .w_data(w_data),
      .r_en(r_en), .r_adrs(r_adrs), .r_data(r_data1), .r_valid(r_valid1));

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mem_m [16];
   logic        m_busy = 1'b1;
   logic [3:0]  m_cnt  = '0;
   logic [1:0]  m_rv   = '0;
   logic        chk_en = 1'b0;
   logic [31:0] exp_q [4][$];      // index = dut*2 + port
   logic [31:0] last_exp [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge_m(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) if (be[i]) res[i*8 +: 8] = nw[i*8 +: 8];
      return res;
   endfunction

   // Apply one cycle of stimulus and predict its effect at the next falling edge.
   task automatic drive(input logic we, input logic [3:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input logic [1:0] re,
                        input logic [3:0] ra0, input logic [3:0] ra1, input logic clr);
      logic [3:0] ra [2];
      @(posedge clk);
      w_en = we; w_adrs = wa; w_be = be; w_data = wd;
      r_en = re; r_adrs = {ra1, ra0}; clear_req = clr;
      ra[0] = ra0; ra[1] = ra1;
      m_rv = 2'b00;
      if (m_busy) begin
         mem_m[m_cnt] = '0;
         if (m_cnt == 4'd15) m_busy = 1'b0;
         m_cnt = m_cnt + 4'd1;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (re[p]) begin
               m_rv[p] = 1'b1;
               exp_q[p].push_back(mem_m[ra[p]]);
               exp_q[2+p].push_back((we && wa == ra[p]) ? merge_m(mem_m[ra[p]], wd, be)
                                                        : mem_m[ra[p]]);
            end
         end
         if (we) mem_m[wa] = merge_m(mem_m[wa], wd, be);
         if (clr) begin
            m_busy = 1'b1;
            m_cnt  = '0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, 32'd0, 2'b00, 4'd0, 4'd0, 1'b0);
   endtask

   task automatic read_all();
      for (int a = 0; a < 16; a++)
         drive(1'b0, 4'd0, 4'd0, 32'd0, 2'b11, 4'(a), 4'(15 - a), 1'b0);
   endtask

   task automatic model_reset();
      m_busy = 1'b1;
      m_cnt  = '0;
      m_rv   = '0;
      for (int i = 0; i < 4; i++) last_exp[i] = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy0"},   32'(busy0),    32'd1);
      check({tag, "_busy1"},   32'(busy1),    32'd1);
      check({tag, "_rvalid0"}, 32'(r_valid0), 32'd0);
      check({tag, "_rvalid1"}, 32'(r_valid1), 32'd0);
      check({tag, "_rdata0_lo"}, r_data0[31:0],  32'd0);
      check({tag, "_rdata0_hi"}, r_data0[63:32], 32'd0);
      check({tag, "_rdata1_lo"}, r_data1[31:0],  32'd0);
      check({tag, "_rdata1_hi"}, r_data1[63:32], 32'd0);
   endtask

   // Per-edge monitor: busy, valid and data of both instances against the model.
   always begin
      @(negedge clk);
      #1;
      if (chk_en) begin
         check("busy_old", 32'(busy0), 32'(m_busy));
         check("busy_new", 32'(busy1), 32'(m_busy));
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               logic [31:0] got;
               logic        gv;
               int          idx;
               idx = d*2 + p;
               got = (d == 0) ? r_data0[p*32 +: 32] : r_data1[p*32 +: 32];
               gv  = (d == 0) ? r_valid0[p] : r_valid1[p];
               check($sformatf("r_valid_d%0d_p%0d", d, p), 32'(gv), 32'(m_rv[p]));
               if (m_rv[p]) begin
                  if (exp_q[idx].size() == 0) check($sformatf("sb_empty_d%0d_p%0d", d, p), 32'd1, 32'd0);
                  else last_exp[idx] = exp_q[idx].pop_front();
               end
               check($sformatf("r_data_d%0d_p%0d", d, p), got, last_exp[idx]);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
      model_reset();

      // Reset held: outputs cleared, sweep pending.
      repeat (3) @(negedge clk);
      #2;
      check_reset_outputs("in_reset");
      reset = 1'b1;
      chk_en = 1'b1;

      // Power-up sweep, then every word reads zero.
      idle(16);
      read_all();

      // Full write followed by a single-lane write.
      drive(1'b1, 4'd3, 4'b1111, 32'hDEAD_BEEF, 2'b00, 4'd0, 4'd0, 1'b0);
      drive(1'b1, 4'd3, 4'b0001, 32'h0000_00AA, 2'b00, 4'd0, 4'd0, 1'b0);
      drive(1'b0, 4'd0, 4'd0,    32'd0,         2'b01, 4'd3, 4'd0, 1'b0);
      drive(1'b1, 4'd3, 4'b0000, 32'h1234_5678, 2'b10, 4'd0, 4'd3, 1'b0);
      drive(1'b0, 4'd0, 4'd0,    32'd0,         2'b10, 4'd0, 4'd3, 1'b0);

      // Read-during-write, full word and partial lanes.
      drive(1'b1, 4'd5, 4'b1111, 32'h1111_1111, 2'b00, 4'd0, 4'd0, 1'b0);
      drive(1'b1, 4'd5, 4'b1111, 32'h2222_2222, 2'b01, 4'd5, 4'd0, 1'b0);
      drive(1'b0, 4'd0, 4'd0,    32'd0,         2'b01, 4'd5, 4'd0, 1'b0);
      drive(1'b1, 4'd6, 4'b1111, 32'h1234_5678, 2'b00, 4'd0, 4'd0, 1'b0);
      drive(1'b1, 4'd6, 4'b1001, 32'hAB00_00CD, 2'b11, 4'd6, 4'd6, 1'b0);
      drive(1'b0, 4'd0, 4'd0,    32'd0,         2'b10, 4'd0, 4'd6, 1'b0);

      // Both ports on one address, then port 1 idles and must hold.
      drive(1'b1, 4'd7, 4'b1111, 32'hCAFE_F00D, 2'b00, 4'd0, 4'd0, 1'b0);
      drive(1'b0, 4'd0, 4'd0,    32'd0,         2'b11, 4'd7, 4'd7, 1'b0);
      drive(1'b0, 4'd0, 4'd0,    32'd0,         2'b01, 4'd3, 4'd7, 1'b0);
      drive(1'b0, 4'd0, 4'd0,    32'd0,         2'b01, 4'd5, 4'd7, 1'b0);

      // Clear request with a same-cycle write and read; traffic during the sweep is ignored.
      drive(1'b1, 4'd9, 4'b1111, 32'h9999_9999, 2'b01, 4'd3, 4'd0, 1'b1);
      for (int i = 0; i < 16; i++)
         drive(1'b1, 4'(i), 4'b1111, 32'hFFFF_FFFF, 2'b11, 4'(i), 4'(i), (i == 4) ? 1'b1 : 1'b0);
      read_all();

      // Leave non-zero read data and memory, then reset in the middle of a sweep.
      drive(1'b1, 4'd2,  4'b1111, 32'h5A5A_5A5A, 2'b00, 4'd0, 4'd0, 1'b0);
      drive(1'b1, 4'd12, 4'b1111, 32'hC0C0_C0C0, 2'b11, 4'd2, 4'd2, 1'b0);
      drive(1'b0, 4'd0,  4'd0,    32'd0,         2'b00, 4'd0, 4'd0, 1'b1);
      idle(8);
      @(negedge clk);
      #2;
      chk_en = 1'b0;
      reset  = 1'b0;
      w_en = 1'b0; r_en = '0; clear_req = 1'b0;
      #1;
      check_reset_outputs("mid_sweep_reset");
      model_reset();
      repeat (2) @(negedge clk);
      #2;
      reset  = 1'b1;
      chk_en = 1'b1;
      idle(16);
      read_all();
      @(negedge clk);
      #2;
      chk_en = 1'b0;

      for (int i = 0; i < 4; i++) check($sformatf("sb_drain_%0d", i), 32'(exp_q[i].size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
